// File: rtl/alu_driver.sv
// Sequences one request at a time into a combinational ALU: registers the operands,
// lets the ALU settle, captures the result and holds it until the consumer takes it.
module alu_driver #(
  parameter int unsigned WORD_SIZE = 16,
  parameter logic [3:0]  IDLE_FUNC = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_func,
  input  logic [WORD_SIZE-1:0] req_op1,
  input  logic [WORD_SIZE-1:0] req_op2,
  output logic [3:0]           alu_func,
  output logic [WORD_SIZE-1:0] alu_op1,
  output logic [WORD_SIZE-1:0] alu_op2,
  input  logic [WORD_SIZE-1:0] alu_a_result,
  input  logic                 alu_b_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_func,
  output logic [WORD_SIZE-1:0] rsp_a,
  output logic                 rsp_b,
  output logic [15:0]          op_count
);

  // Branch function codes, matching the opcodes.v encoding.
  localparam logic [3:0] FUNC_BEQ = 4'h8;
  localparam logic [3:0] FUNC_BNE = 4'h9;
  localparam logic [3:0] FUNC_BGZ = 4'hA;
  localparam logic [3:0] FUNC_BLZ = 4'hB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]           state_q,     state_d;
  logic [3:0]           alu_func_q,  alu_func_d;
  logic [WORD_SIZE-1:0] alu_op1_q,   alu_op1_d;
  logic [WORD_SIZE-1:0] alu_op2_q,   alu_op2_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           rsp_func_q,  rsp_func_d;
  logic [WORD_SIZE-1:0] rsp_a_q,     rsp_a_d;
  logic                 rsp_b_q,     rsp_b_d;
  logic [15:0]          op_count_q,  op_count_d;
  logic                 is_branch;

  assign is_branch = (alu_func_q == FUNC_BEQ) || (alu_func_q == FUNC_BNE) ||
                     (alu_func_q == FUNC_BGZ) || (alu_func_q == FUNC_BLZ);

  always_comb begin
    state_d     = state_q;
    alu_func_d  = alu_func_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_func_d  = rsp_func_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_func_d = req_func;
          alu_op1_d  = req_op1;
          alu_op2_d  = req_op2;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_SETTLE;
      S_SETTLE: begin
        rsp_func_d  = alu_func_q;
        rsp_valid_d = 1'b1;
        if (is_branch) begin
          rsp_a_d = '0;
          rsp_b_d = alu_b_result;
        end else begin
          rsp_a_d = alu_a_result;
          rsp_b_d = 1'b0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        // IDLE_FUNC is restored on the consume edge so the next issue always changes alu_func.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          alu_func_d  = IDLE_FUNC;
          op_count_d  = op_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      alu_func_q  <= IDLE_FUNC;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_func_q  <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_func_q  <= alu_func_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_func_q  <= rsp_func_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign alu_func  = alu_func_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_func  = rsp_func_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign op_count  = op_count_q;

endmodule
